// File: rtl/pipe_hazard_sched_pkg.sv
// Shared pipeline-control definitions: scheduler states, default timing limits
// and the stage-register control bundle driven by the scheduler.
package pipe_hazard_sched_pkg;

    localparam int REG_W            = 5;
    localparam int DEF_MEM_TIMEOUT  = 255;
    localparam int DEF_DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } sched_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctl_t;

    // Bit order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id/id_ex flushes
    localparam stage_ctl_t CTL_RUN   = 7'b11111_00;
    localparam stage_ctl_t CTL_IDLE  = 7'b00000_00;
    localparam stage_ctl_t CTL_STALL = 7'b00111_01;
    localparam stage_ctl_t CTL_FLUSH = 7'b11111_11;
    localparam stage_ctl_t CTL_DRAIN = 7'b01111_11;

endpackage

// File: rtl/pipe_hazard_sched_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds
// either source operand of the instruction in ID.
module hazard_detect
    import pipe_hazard_sched_pkg::*;
(
    input  logic             memread,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             load_use
);

    always_comb begin
        load_use = memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
    end

endmodule

// File: rtl/pipe_hazard_sched.sv
// Pipeline hazard scheduler: load-use stalls, branch flushes, data-memory
// freeze with timeout, and a halt/drain sequence ending in a stopped pipeline.
module pipe_hazard_sched
    import pipe_hazard_sched_pkg::*;
#(
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] if_id_rs1,
    input  logic [REG_W-1:0] if_id_rs2,
    input  logic             id_ex_memread,
    input  logic             id_ex_halt,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_memop,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dmem_req,
    output logic             halted,
    output logic             mem_err,
    output logic [15:0]      stall_cnt
);

    localparam int WW = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT)  : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    sched_state_t  state;
    logic [WW-1:0] wait_cnt;
    logic [DW-1:0] drain_cnt;
    logic          load_use;
    logic          active;
    logic          freeze;
    logic          take_halt;
    logic          do_stall;
    stage_ctl_t    ctl;

    hazard_detect u_hazard_detect (
        .memread  (id_ex_memread),
        .rd       (id_ex_rd),
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .load_use (load_use)
    );

    // MEM_WAIT behaves exactly like RUN once the ack releases the freeze,
    // so a halt or hazard coinciding with the ack is not lost.
    always_comb begin
        active    = (state == ST_RUN) || (state == ST_MEM_WAIT);
        dmem_req  = (state != ST_HALTED) && ex_mem_memop;
        freeze    = dmem_req && !dmem_ack;
        take_halt = active && !freeze && !ex_branch_taken && id_ex_halt;
        do_stall  = active && !freeze && !ex_branch_taken && !id_ex_halt && load_use;

        ctl = CTL_RUN;
        if (state == ST_HALTED || freeze) ctl = CTL_IDLE;
        else if (state == ST_DRAIN)       ctl = CTL_DRAIN;
        else if (ex_branch_taken)         ctl = CTL_FLUSH;
        else if (id_ex_halt)              ctl = CTL_DRAIN;
        else if (load_use)                ctl = CTL_STALL;
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign id_ex_en    = ctl.id_ex_en;
    assign ex_mem_en   = ctl.ex_mem_en;
    assign mem_wb_en   = ctl.mem_wb_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (do_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;

            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze) begin
                        if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) begin
                            state   <= ST_HALTED;
                            halted  <= 1'b1;
                            mem_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                            state    <= ST_MEM_WAIT;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (take_halt) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!freeze) begin
                        if (int'(drain_cnt) + 1 >= DRAIN_CYCLES) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Self-checking bench for pipe_hazard_sched: single-cycle vector table,
// hand-written multi-cycle sequences, and randomized traffic against a model.
module tb_pipe_hazard_sched;

    localparam int MT = 8;
    localparam int DC = 3;

    localparam logic [6:0] C_ALL   = 7'b11111_00;
    localparam logic [6:0] C_FRZ   = 7'b00000_00;
    localparam logic [6:0] C_STALL = 7'b00111_01;
    localparam logic [6:0] C_BR    = 7'b11111_11;
    localparam logic [6:0] C_HALT  = 7'b01111_11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
    logic        id_ex_memread = 1'b0, id_ex_halt = 1'b0, ex_branch_taken = 1'b0;
    logic        ex_mem_memop = 1'b0, dmem_ack = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, dmem_req, halted, mem_err;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_hazard_sched #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_halt(id_ex_halt), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mem_memop(ex_mem_memop), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dmem_req(dmem_req), .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: progress counters and flags, outputs derived from the rules
    bit m_halted, m_drain, m_err;
    int m_wait, m_drained, m_stall;

    function automatic logic [7:0] dut_out();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, dmem_req};
    endfunction

    function automatic bit m_lu();
        return id_ex_memread && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    endfunction

    function automatic logic [7:0] model_out();
        logic req;
        req = !m_halted && ex_mem_memop;
        if (m_halted)              return 8'h00;
        if (req && !dmem_ack)      return {C_FRZ, 1'b1};
        if (m_drain)               return {C_HALT, req};
        if (ex_branch_taken)       return {C_BR, req};
        if (id_ex_halt)            return {C_HALT, req};
        if (m_lu())                return {C_STALL, req};
        return {C_ALL, req};
    endfunction

    function automatic void model_next();
        bit frz;
        frz = !m_halted && ex_mem_memop && !dmem_ack;
        if (m_halted) return;
        if (frz) begin
            if (!m_drain) begin
                m_wait++;
                if (m_wait >= MT) begin m_halted = 1; m_err = 1; end
            end
        end else if (m_drain) begin
            m_drained++;
            if (m_drained >= DC) m_halted = 1;
        end else begin
            m_wait = 0;
            if (ex_branch_taken) ;
            else if (id_ex_halt) begin m_drain = 1; m_drained = 0; end
            else if (m_lu() && m_stall < 65535) m_stall++;
        end
    endfunction

    function automatic void model_reset();
        m_halted = 0; m_drain = 0; m_err = 0; m_wait = 0; m_drained = 0; m_stall = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic mr, input logic hlt, input logic br,
                          input logic mop, input logic ack);
        if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
        id_ex_memread = mr; id_ex_halt = hlt; ex_branch_taken = br;
        ex_mem_memop = mop; dmem_ack = ack;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance();
        model_next();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        mr, hlt, br, mop, ack;
        logic [6:0]  ctl;
        logic        req;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{5'd1,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 1'b0, 16'd1};
        vecs[1]  = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ALL,   1'b0, 16'd0};
        vecs[2]  = '{5'd5,  5'd2, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,    1'b0, 16'd0};
        vecs[3]  = '{5'd3,  5'd4, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_ALL,   1'b1, 16'd0};
        vecs[4]  = '{5'd5,  5'd5, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ,   1'b1, 16'd0};
        vecs[5]  = '{5'd1,  5'd2, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_HALT,  1'b0, 16'd0};
        vecs[6]  = '{5'd1,  5'd2, 5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,    1'b0, 16'd0};
        vecs[7]  = '{5'd7,  5'd1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ALL,   1'b0, 16'd0};
        vecs[8]  = '{5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 1'b0, 16'd1};
        vecs[9]  = '{5'd6,  5'd6, 5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_HALT,  1'b0, 16'd0};
        vecs[10] = '{5'd4,  5'd9, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_STALL, 1'b1, 16'd1};

        @(negedge clk);
        settle();
        check("reset_outputs", {24'd0, dut_out()}, {24'd0, C_ALL, 1'b0});
        check("reset_regs", {13'd0, halted, mem_err, stall_cnt}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
                   vecs[i].hlt, vecs[i].br, vecs[i].mop, vecs[i].ack);
            settle();
            check($sformatf("vec%0d_ctl", i), {24'd0, dut_out()}, {24'd0, vecs[i].ctl, vecs[i].req});
            advance();
            check($sformatf("vec%0d_stall", i), {16'd0, stall_cnt}, {16'd0, vecs[i].stall});
        end

        // Memory access acknowledged on the fifth cycle: four frozen cycles
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("wait_frz%0d", k), {24'd0, dut_out()}, {24'd0, C_FRZ, 1'b1});
            advance();
        end
        dmem_ack = 1'b1;
        settle();
        check("wait_release", {24'd0, dut_out()}, {24'd0, C_ALL, 1'b1});
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("wait_after", {23'd0, dut_out(), halted}, {23'd0, C_ALL, 1'b0, 1'b0});

        // Timeout: no ack for MT cycles
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < MT; k++) begin
            settle();
            if (k == MT - 1)
                check("tmo_last_wait", {22'd0, dut_out(), halted, mem_err}, {22'd0, C_FRZ, 1'b1, 2'b00});
            advance();
        end
        settle();
        check("tmo_halted", {22'd0, dut_out(), halted, mem_err}, {22'd0, 8'h00, 2'b11});

        // Halt and drain
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        check("halt_entry", {24'd0, dut_out()}, {24'd0, C_HALT, 1'b0});
        advance();
        id_ex_halt = 1'b0;
        for (int d = 0; d < DC; d++) begin
            settle();
            check($sformatf("drain%0d", d), {23'd0, dut_out(), halted}, {23'd0, C_HALT, 1'b0, 1'b0});
            advance();
        end
        settle();
        check("drain_done", {23'd0, dut_out(), halted}, {23'd0, 8'h00, 1'b1});

        // Freeze in drain does not advance the drain count
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); advance();
        ex_mem_memop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            check($sformatf("drain_frz%0d", k), {24'd0, dut_out()}, {24'd0, C_FRZ, 1'b1});
            advance();
        end
        dmem_ack = 1'b1;
        settle();
        check("drain_ack", {23'd0, dut_out(), halted}, {23'd0, C_HALT, 1'b1, 1'b0});
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("drain_last", {23'd0, dut_out(), halted}, {23'd0, C_HALT, 1'b0, 1'b0});
        advance();
        ex_mem_memop = 1'b1;
        settle();
        check("drain_halted_noreq", {23'd0, dut_out(), halted}, {23'd0, 8'h00, 1'b1});

        // Reset pulse mid-drain
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); advance();
        #3 reset = 1'b0;
        #1;
        check("rst_mid_drain", {23'd0, dut_out(), halted}, {23'd0, C_ALL, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        set_in(2, 0, 2, 1, 0, 0, 0, 0);
        settle();
        check("post_rst_stall", {23'd0, dut_out(), halted}, {23'd0, C_STALL, 1'b0, 1'b0});
        advance();
        check("post_rst_cnt", {16'd0, stall_cnt}, 32'd1);

        // Reset pulse mid-wait leaves no residual freeze
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        settle(); advance();
        settle(); advance();
        #3 reset = 1'b0;
        ex_mem_memop = 1'b0;
        #1;
        check("rst_mid_wait", {24'd0, dut_out()}, {24'd0, C_ALL, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        settle();
        check("post_wait_zero", {24'd0, dut_out()}, {24'd0, C_ALL, 1'b1});
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("post_wait_run", {7'd0, dut_out(), halted, stall_cnt}, {7'd0, C_ALL, 1'b0, 1'b0, 16'd0});

        // Randomized traffic against the model
        begin
            bit mem_busy;
            int halt_age;
            mem_busy = 0;
            halt_age = 0;
            do_reset();
            for (int i = 0; i < 2500; i++) begin
                if (m_halted && halt_age > 2) begin
                    do_reset();
                    mem_busy = 0;
                    halt_age = 0;
                end
                if (!mem_busy) mem_busy = ($urandom_range(0, 4) == 0);
                set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
                       ($urandom_range(0, 5) == 0), mem_busy,
                       mem_busy && ($urandom_range(0, 4) == 0));
                settle();
                check($sformatf("rand%0d", i),
                      {6'd0, dut_out(), halted, mem_err, stall_cnt},
                      {6'd0, model_out(), m_halted, m_err, 16'(m_stall)});
                if (dmem_ack) mem_busy = 0;
                advance();
                if (m_halted) halt_age++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
